osd_mam_wb_adapter: RTL and testbench
=====================================

Name: osd_mam_wb_adapter

Overview:
- Downstream stage of the memory access module (MAM). Consumes its generic request/write/read port and runs Wishbone B3 classic/burst cycles on a system memory bus.
- One MAM request becomes one Wishbone cycle of 1..16383 beats. CYC_O is held for the whole request.
- Each read beat is buffered in a single register, so MAM backpressure never violates Wishbone timing.

Parameters:
- DATA_WIDTH, 16: data width in bits; multiple of 16, equal to the MAM's DATA_WIDTH.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  MAM request valid
- req_ready  out  1  request accepted
- req_rw  in  1  0 read, 1 write
- req_addr  in  ADDR_WIDTH  byte base address
- req_burst  in  1  0 single, 1 incrementing burst
- req_beats  in  14  beat count
- write_valid  in  1  write data valid
- write_data  in  DATA_WIDTH  write data
- write_strb  in  DATA_WIDTH/8  byte strobe; used for single writes only
- write_ready  out  1  write data accepted
- read_valid  out  1  read data valid
- read_data  out  DATA_WIDTH  read data
- read_ready  in  1  read data consumed
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADDR_WIDTH  byte address
- wb_dat_o  out  DATA_WIDTH  write data
- wb_sel_o  out  DATA_WIDTH/8  byte select
- wb_cti_o  out  3  cycle type identifier
- wb_bte_o  out  2  burst type extension; constant 2'b00 (linear)
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- wb_dat_i  in  DATA_WIDTH  read data

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - state=IDLE.
  - All outputs 0, except req_ready=1 and wb_bte_o=0.
  - Pending beats are discarded; no completion is signalled.
- States: IDLE, WDATA, WBUS, RBUS, RHOLD.
- IDLE:
  - req_ready=1 (combinational from state).
  - On req_valid, latch rw, addr, burst and beats. Beats are forced to 1 when burst=0.
  - sel = burst ? all-ones : write_strb. write_strb is sampled in this same cycle.
  - Next state: WDATA if rw, else RBUS.
  - A latched beat count of 0 (burst=1, beats=0) completes immediately: stay in IDLE, no bus cycle.
- WDATA:
  - write_ready=1. wb_cyc_o=1, wb_stb_o=0.
  - On write_valid: register write_data into wb_dat_o, go to WBUS.
- WBUS: wb_cyc_o=1, wb_stb_o=1, wb_we_o=1. On ack/err:
  - beats_left decrements.
  - Address advances by DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wrap-around permitted).
  - Go to IDLE if beats_left was 1, else WDATA.
- RBUS: wb_cyc_o=1, wb_stb_o=1, wb_we_o=0, sel all-ones. On ack/err:
  - Capture wb_dat_i into read_data, set read_valid=1, go to RHOLD (wb_stb_o=0).
- RHOLD: wb_cyc_o=1. On read_ready, clear read_valid, then:
  - IDLE if this was the last beat, else RBUS with address incremented.
  - Beats_left decrements on the transition.
- Latency, read: req accept -> STB at +1 cycle; ack -> read_valid at +1 cycle; read_ready -> next STB at +1 cycle.
- Latency, write: write handshake -> STB at +1 cycle.
- Cycle type:
  - wb_cti_o = 3'b000 for single requests.
  - For bursts: 3'b010 while beats_left>1, 3'b111 on the final beat.
- Simultaneous ack and err: treated as one termination; err is reported (see Optional Feature).
- An ack while STB=0 is ignored.
- wb_adr_o, wb_we_o, wb_sel_o and wb_dat_o are stable while STB=1.
- Widths:
  - beats_left is 14 bits.
  - Address increment is a constant (DATA_WIDTH/8) in ADDR_WIDTH arithmetic; no carry out.

Optional Feature:
- Macro: OSD_MAM_WB_ADAPTER_ERR_EN.
- Defined:
  - Adds output bus_error (1 bit), reset 0.
  - bus_error is set sticky on any wb_err_i termination and cleared when the next request is accepted in IDLE.
  - read_data returns all-zeros for errored read beats.
- Undefined:
  - No bus_error port.
  - wb_err_i behaves exactly like wb_ack_i; read_data takes wb_dat_i.

Test Plan:
- Single read at 0x0000_1000, DATA_WIDTH=16: slave acks 1 cycle after STB with 0xBEEF. Required: wb_cti_o=000, sel=2'b11, read_valid with read_data=0xBEEF. Only after read_ready is CYC dropped and req_ready raised.
- Burst write, beats=4, addr 0x100, DATA_WIDTH=32, data 1,2,3,4: adr 0x100, 0x104, 0x108, 0x10C; cti 010, 010, 010, 111; sel=4'hF; CYC continuous; IDLE after 4th ack.
- Single write, write_strb=2'b01, data 0x00AA: wb_sel_o=2'b01, cti=000, exactly one STB.
- Burst read, beats=3, read_ready held low 5 cycles per beat: STB low in RHOLD, no extra acks accepted, 3 beats delivered in order.
- Reset asserted during beat 2 of a 4-beat write: CYC/STB drop in the same cycle; after release req_ready=1 and a new single read completes normally.
- With OSD_MAM_WB_ADAPTER_ERR_EN: err on beat 1 of a 2-beat read. Required: bus_error=1, read_data=0, burst continues to beat 2, bus_error clears on the next req accept.

Source files
------------

// File: rtl/osd_mam_wb_adapter.sv
// MAM request/write/read port to Wishbone B3 classic/burst master; one MAM request maps to one CYC.
// Optional OSD_MAM_WB_ADAPTER_ERR_EN adds a sticky bus_error output and zeroes errored read beats.
module osd_mam_wb_adapter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [13:0]             req_beats,
  input  logic                    write_valid,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    write_ready,
  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_ready,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [2:0]              wb_cti_o,
  output logic [1:0]              wb_bte_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
  ,
  output logic                    bus_error
`endif
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WDATA, WBUS, RBUS, RHOLD} state_t;

  state_t                  state, state_next;
  logic                    burst;
  logic [13:0]             beats_left;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [SW-1:0]           sel;
  logic [DATA_WIDTH-1:0]   dat_out;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic [13:0]             beats_eff;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic                    term;

  assign beats_eff = req_burst ? req_beats : 14'd1;
  assign addr_inc  = addr + ADDR_WIDTH'(SW);
  // Only a strobed beat can terminate; stray acks in WDATA/RHOLD are ignored.
  assign term      = (state == WBUS || state == RBUS) && (wb_ack_i || wb_err_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid && beats_eff != 14'd0) state_next = req_rw ? WDATA : RBUS;
      WDATA:   if (write_valid) state_next = WBUS;
      WBUS:    if (term) state_next = (beats_left == 14'd1) ? IDLE : WDATA;
      RBUS:    if (term) state_next = RHOLD;
      RHOLD:   if (read_ready) state_next = (beats_left == 14'd1) ? IDLE : RBUS;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    write_ready = (state == WDATA);
    wb_cyc_o    = (state != IDLE);
    wb_stb_o    = (state == WBUS) || (state == RBUS);
    wb_we_o     = (state == WBUS);
    wb_sel_o    = '0;
    if (state == WBUS) wb_sel_o = sel;
    else if (state == RBUS) wb_sel_o = '1;
    wb_cti_o    = 3'b000;
    if (state != IDLE && burst) wb_cti_o = (beats_left > 14'd1) ? 3'b010 : 3'b111;
    wb_bte_o    = 2'b00;
    wb_adr_o    = addr;
    wb_dat_o    = dat_out;
    read_valid  = rvalid;
    read_data   = rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst      <= 1'b0;
      beats_left <= '0;
      addr       <= '0;
      sel        <= '0;
      dat_out    <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
      bus_error  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          burst      <= req_burst;
          beats_left <= beats_eff;
          addr       <= req_addr;
          sel        <= req_burst ? '1 : write_strb;
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
          bus_error  <= 1'b0;
`endif
        end
        WDATA: if (write_valid) dat_out <= write_data;
        WBUS: if (term) begin
          beats_left <= beats_left - 14'd1;
          addr       <= addr_inc;
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
          if (wb_err_i) bus_error <= 1'b1;
`endif
        end
        RBUS: if (term) begin
          rvalid <= 1'b1;
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
          rdata  <= wb_err_i ? '0 : wb_dat_i;
          if (wb_err_i) bus_error <= 1'b1;
`else
          rdata  <= wb_dat_i;
`endif
        end
        RHOLD: if (read_ready) begin
          rvalid     <= 1'b0;
          beats_left <= beats_left - 14'd1;
          addr       <= addr_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_mam_wb_adapter.sv
// Randomized bench for osd_mam_wb_adapter: transaction-level beat/readback model, one per-cycle compare step.
module tb_osd_mam_wb_adapter;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_rw = 1'b0, req_burst = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [13:0]   req_beats = '0;
  logic          write_valid = 1'b0, write_ready;
  logic [DW-1:0] write_data = '0;
  logic [SW-1:0] write_strb = '0;
  logic          read_valid, read_ready = 1'b0;
  logic [DW-1:0] read_data;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic          wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
  logic          bus_error;
`endif

  always #5 clk = ~clk;

  osd_mam_wb_adapter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr),
    .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_data(write_data), .write_strb(write_strb), .write_ready(write_ready),
    .read_valid(read_valid), .read_data(read_data), .read_ready(read_ready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
    , .bus_error(bus_error)
`endif
  );

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [DW-1:0] dat;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rd_q[$];
  logic          model_err = 1'b0;
  int            gen_idx = 0, cur_req = -1, beat_cnt = 0, rd_cnt = 0;
  int unsigned   reqs_left = 0;
  int unsigned   n_cmp = 0, n_fail = 0;

  logic [AW-1:0] lit_adr [4] = '{32'h100, 32'h102, 32'h104, 32'h106};
  logic [2:0]    lit_cti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
  logic [DW-1:0] lit_dat [4] = '{16'd1, 16'd2, 16'd3, 16'd4};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Build the expected bus beats for one request from address/burst rules.
  task automatic gen_push();
    logic          rw, bu;
    logic [13:0]   bt;
    logic [AW-1:0] a;
    logic [SW-1:0] st;
    int            n;
    beat_t         b;
    rw = $urandom_range(1); bu = $urandom_range(1);
    bt = 14'($urandom_range(5)); st = SW'($urandom);
    a  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom;
    case (gen_idx)
      0:   begin rw = 0; bu = 0; bt = 14'd7; a = 32'h1000; st = 2'b10; end
      1:   begin rw = 1; bu = 1; bt = 14'd4; a = 32'h100; end
      2:   begin rw = 1; bu = 0; bt = 14'd5; a = 32'h2000; st = 2'b01; end
      3:   begin rw = 0; bu = 1; bt = 14'd3; a = 32'h400; end
      4:   begin rw = 0; bu = 1; bt = 14'd0; a = 32'h600; end
      5:   begin rw = 0; bu = 1; bt = 14'd2; a = 32'h500; end
      6:   begin rw = 1; bu = 1; bt = 14'd17; a = 32'hFFFF_FFF0; end
      100: begin rw = 0; bu = 0; bt = 14'd1; a = 32'h3000; end
      default: ;
    endcase
    req_valid = 1'b1; req_rw = rw; req_burst = bu; req_beats = bt; req_addr = a; write_strb = st;
    n = bu ? int'(bt) : 1;
    for (int k = 0; k < n; k++) begin
      b.adr = a + AW'(SW * k);
      b.we  = rw;
      b.sel = (rw && !bu) ? st : '1;
      b.cti = !bu ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
      b.dat = (gen_idx == 1) ? DW'(k + 1) : (gen_idx == 2) ? 16'h00AA : DW'($urandom);
      if (!rw) b.dat = '0;
      else wq.push_back(b.dat);
      exp_q.push_back(b);
    end
    model_err = 1'b0;
    cur_req = gen_idx; beat_cnt = 0; rd_cnt = 0;
    gen_idx++;
    reqs_left--;
  endtask

  // One cycle: compare DUT outputs (stable at negedge) against the model, then drive the next inputs.
  task automatic step();
    beat_t b;
    logic  idle_exp;
    idle_exp = (exp_q.size() == 0) && (rd_q.size() == 0);
    chk("req_ready", req_ready, idle_exp);
    chk("cyc", wb_cyc_o, !idle_exp);
    chk("bte", wb_bte_o, 2'b00);
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
    chk("bus_error", bus_error, model_err);
`endif
    if (wb_stb_o) begin
      chk("stb_expected", exp_q.size() > 0, 1'b1);
      chk("stb_vs_write_ready", write_ready, 1'b0);
      chk("stb_vs_read_valid", read_valid, 1'b0);
      if (exp_q.size() > 0) begin
        chk("adr", wb_adr_o, exp_q[0].adr);
        chk("we", wb_we_o, exp_q[0].we);
        chk("sel", wb_sel_o, exp_q[0].sel);
        chk("cti", wb_cti_o, exp_q[0].cti);
        if (exp_q[0].we) chk("dat_o", wb_dat_o, exp_q[0].dat);
      end
      if (cur_req == 0) begin
        chk("lit_rd_adr", wb_adr_o, 32'h1000);
        chk("lit_rd_cti", wb_cti_o, 3'b000);
        chk("lit_rd_sel", wb_sel_o, 2'b11);
      end
      if (cur_req == 1 && beat_cnt < 4) begin
        chk("lit_bw_adr", wb_adr_o, lit_adr[beat_cnt]);
        chk("lit_bw_cti", wb_cti_o, lit_cti[beat_cnt]);
        chk("lit_bw_dat", wb_dat_o, lit_dat[beat_cnt]);
        chk("lit_bw_sel", wb_sel_o, 2'b11);
      end
      if (cur_req == 2) begin
        chk("lit_sw_sel", wb_sel_o, 2'b01);
        chk("lit_sw_dat", wb_dat_o, 16'h00AA);
        chk("lit_sw_beat", beat_cnt, 0);
      end
    end
    if (write_ready) chk("write_ready_expected", wq.size() > 0, 1'b1);
    if (read_valid) begin
      chk("read_valid_expected", rd_q.size() > 0, 1'b1);
      if (rd_q.size() > 0) chk("read_data", read_data, rd_q[0]);
      if (cur_req == 0) chk("lit_read_data", read_data, 16'hBEEF);
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
      if (cur_req == 5 && rd_cnt == 0) begin
        chk("lit_err_rdata", read_data, 16'h0000);
        chk("lit_err_flag", bus_error, 1'b1);
      end
`endif
    end

    req_valid = 1'b0;
    req_addr = $urandom; req_beats = 14'($urandom); req_rw = $urandom_range(1);
    if (req_ready && idle_exp && reqs_left > 0 && $urandom_range(3) != 0) gen_push();

    if (write_ready && wq.size() > 0 && $urandom_range(2) != 0) begin
      write_valid = 1'b1;
      write_data  = wq.pop_front();
    end else begin
      write_valid = !write_ready && $urandom_range(1) == 1;
      write_data  = DW'($urandom);
    end

    wb_dat_i = (cur_req == 0) ? 16'hBEEF : DW'($urandom);
    wb_ack_i = ($urandom_range(2) == 0);
    wb_err_i = ($urandom_range(7) == 0);
    if (cur_req == 5 && wb_stb_o) begin
      wb_err_i = (beat_cnt == 0);
      wb_ack_i = (beat_cnt != 0);
    end
    if (wb_stb_o && (wb_ack_i || wb_err_i) && exp_q.size() > 0) begin
      b = exp_q.pop_front();
      beat_cnt++;
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
      if (wb_err_i) model_err = 1'b1;
      if (!b.we) rd_q.push_back(wb_err_i ? '0 : wb_dat_i);
`else
      if (!b.we) rd_q.push_back(wb_dat_i);
`endif
    end

    if (read_valid && rd_q.size() > 0 && $urandom_range(2) == 0) begin
      read_ready = 1'b1;
      void'(rd_q.pop_front());
      rd_cnt++;
    end else begin
      read_ready = !read_valid && $urandom_range(1) == 1;
    end
  endtask

  task automatic run_phase(input int unsigned limit);
    int unsigned c = 0;
    while ((reqs_left > 0 || exp_q.size() > 0 || rd_q.size() > 0) && c < limit) begin
      @(negedge clk);
      step();
      c++;
    end
    if (c >= limit) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: phase still busy after %0d cycles, %0d requests left", c, reqs_left);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_cyc"}, wb_cyc_o, 1'b0);
    chk({tag, "_stb"}, wb_stb_o, 1'b0);
    chk({tag, "_we"}, wb_we_o, 1'b0);
    chk({tag, "_adr"}, wb_adr_o, 32'h0);
    chk({tag, "_dat_o"}, wb_dat_o, 16'h0);
    chk({tag, "_sel"}, wb_sel_o, 2'b00);
    chk({tag, "_cti"}, wb_cti_o, 3'b000);
    chk({tag, "_bte"}, wb_bte_o, 2'b00);
    chk({tag, "_write_ready"}, write_ready, 1'b0);
    chk({tag, "_read_valid"}, read_valid, 1'b0);
    chk({tag, "_read_data"}, read_data, 16'h0);
`ifdef OSD_MAM_WB_ADAPTER_ERR_EN
    chk({tag, "_bus_error"}, bus_error, 1'b0);
`endif
  endtask

  initial begin
    int unsigned w;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    reqs_left = 60;
    run_phase(20000);

    // Reset in the middle of beat 2 of a 4-beat write burst.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_burst = 1'b1; req_beats = 14'd4; req_addr = 32'h200;
    write_valid = 1'b1; write_data = 16'h1111; wb_ack_i = 1'b1; wb_err_i = 1'b0; read_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!(wb_stb_o && wb_adr_o == 32'h202) && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("reset_test_reached_beat2", w < 20, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    write_valid = 1'b0; wb_ack_i = 1'b0;
    exp_q.delete(); wq.delete(); rd_q.delete();
    model_err = 1'b0; cur_req = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    gen_idx = 100;
    reqs_left = 40;
    run_phase(20000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
